// File: rtl/magia_mon_pkg.sv
// Shared types and default address map for the AXI print monitor.
// Optional MAGIA_MON_TIMESTAMP_EN adds a cycle timestamp to char entries.
package magia_mon_pkg;

    typedef enum logic [1:0] {
        KIND_NONE   = 2'd0,
        KIND_STDOUT = 2'd1,
        KIND_STDERR = 2'd2,
        KIND_EOC    = 2'd3
    } kind_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } burst_state_e;

    // Channel field is fixed-width so the structs need no parameters; N_CH <= 256.
    localparam int unsigned CH_FIELD_W = 8;

    localparam logic [31:0] DEF_PRINT_BASE = 32'h5FFF_0000;
    localparam logic [31:0] DEF_EOC_ADDR   = 32'h5C03_0000;
    localparam int unsigned DEF_CH_STRIDE  = 8;

    typedef struct packed {
        kind_e                 kind;
        logic [CH_FIELD_W-1:0] ch;
        logic [7:0]            len;
    } aw_entry_t;

    typedef struct packed {
        logic [7:0]            data;
        logic [CH_FIELD_W-1:0] ch;
`ifdef MAGIA_MON_TIMESTAMP_EN
        logic [63:0]           ts;
`endif
    } char_entry_t;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO (common_cells fifo_v3 subset): registered storage, head visible
// combinationally, push into a full FIFO accepted only when a pop happens the same cycle.
module fifo_v3 #(
    parameter int unsigned DEPTH = 8,
    parameter type         dtype = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dtype             mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    // Head reads as zero when empty so downstream outputs stay clean after reset.
    assign data_o  = empty_o ? dtype'('0) : mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/magia_axi_print_monitor.sv
// Passive AXI4 write-path snooper decoding per-tile stdout/stderr/EOC writes.
// Define MAGIA_MON_TIMESTAMP_EN to add a 64-bit cycle timestamp on ts_o.
module magia_axi_print_monitor
    import magia_mon_pkg::*;
#(
    parameter int unsigned        N_CH       = 4,
    parameter int unsigned        ADDR_W     = 32,
    parameter int unsigned        DATA_W     = 32,
    parameter logic [ADDR_W-1:0]  PRINT_BASE = ADDR_W'(DEF_PRINT_BASE),
    parameter int unsigned        CH_STRIDE  = DEF_CH_STRIDE,
    parameter logic [ADDR_W-1:0]  EOC_ADDR   = ADDR_W'(DEF_EOC_ADDR),
    parameter int unsigned        AW_DEPTH   = 8,
    parameter int unsigned        CHAR_DEPTH = 16,
    localparam int unsigned       CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int unsigned       STRB_W     = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              aw_valid_i,
    input  logic              aw_ready_i,
    input  logic [ADDR_W-1:0] aw_addr_i,
    input  logic [7:0]        aw_len_i,
    input  logic              w_valid_i,
    input  logic              w_ready_i,
    input  logic [DATA_W-1:0] w_data_i,
    input  logic [STRB_W-1:0] w_strb_i,
    input  logic              w_last_i,
    output logic              char_valid_o,
    input  logic              char_ready_i,
    output logic [7:0]        char_data_o,
    output logic [CH_W-1:0]   char_ch_o,
    output logic              err_valid_o,
    output logic [CH_W-1:0]   err_ch_o,
    output logic [31:0]       err_code_o,
    output logic              eoc_o,
    output logic [31:0]       exit_code_o,
    output logic [3:0]        status_o
`ifdef MAGIA_MON_TIMESTAMP_EN
    ,
    output logic [63:0]       ts_o
`endif
);

    function automatic aw_entry_t decode_aw(input logic [ADDR_W-1:0] addr,
                                            input logic [7:0]        len);
        aw_entry_t         e;
        logic [ADDR_W-1:0] off;
        logic [ADDR_W-1:0] chi;
        logic [ADDR_W-1:0] sub;
        e.kind = KIND_NONE;
        e.ch   = '0;
        e.len  = len;
        // Addresses below the base wrap to huge offsets and fall out via the channel check.
        off    = addr - PRINT_BASE;
        chi    = off / ADDR_W'(CH_STRIDE);
        sub    = off % ADDR_W'(CH_STRIDE);
        if (addr == EOC_ADDR) begin
            e.kind = KIND_EOC;
        end else if (chi < ADDR_W'(N_CH)) begin
            e.ch = CH_FIELD_W'(chi);
            if (sub == ADDR_W'(0))      e.kind = KIND_STDERR;
            else if (sub == ADDR_W'(4)) e.kind = KIND_STDOUT;
        end
        return e;
    endfunction

    logic         aw_hs;
    logic         w_hs;
    aw_entry_t    aw_new;
    aw_entry_t    aw_head;
    logic         aw_full;
    logic         aw_empty;
    logic         aw_pop;

    burst_state_e state_q;
    burst_state_e state_d;
    aw_entry_t    cur_q;
    logic [7:0]   beat_q;
    aw_entry_t    cur;
    logic [7:0]   beat;
    logic         beat_en;
    logic         w_orphan;
    logic         len_mis;
    logic         lo_vld;
    logic [7:0]   lo_byte;

    char_entry_t  char_new;
    char_entry_t  char_head;
    logic         char_push;
    logic         char_pop;
    logic         char_full;
    logic         char_empty;

    logic         err_hit;
    logic         eoc_hit;
    logic         err_valid_q;
    logic [CH_W-1:0] err_ch_q;
    logic [31:0]  err_code_q;
    logic         eoc_q;
    logic [31:0]  exit_code_q;
    logic         st_w_early;
    logic         st_aw_ovf;
    logic         st_char_ovf;
    logic         st_len_err;
    logic         unused_ch;

    assign aw_hs  = aw_valid_i & aw_ready_i;
    assign w_hs   = w_valid_i & w_ready_i;
    assign aw_new = decode_aw(aw_addr_i, aw_len_i);

    // NONE entries are queued too so W bursts stay paired with their own AW.
    fifo_v3 #(
        .DEPTH (AW_DEPTH),
        .dtype (aw_entry_t)
    ) i_aw_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (aw_full),
        .empty_o (aw_empty),
        .data_i  (aw_new),
        .push_i  (aw_hs),
        .data_o  (aw_head),
        .pop_i   (aw_pop)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!aw_empty) state_d = (w_hs && w_last_i) ? ST_IDLE : ST_ACTIVE;
            ST_ACTIVE: if (w_hs && w_last_i) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // In IDLE the FIFO head is the burst being opened, so a beat arriving in the
    // pop cycle is processed against it rather than lost.
    always_comb begin
        aw_pop   = (state_q == ST_IDLE) && !aw_empty;
        cur      = (state_q == ST_IDLE) ? aw_head : cur_q;
        beat     = (state_q == ST_IDLE) ? 8'd0 : beat_q;
        beat_en  = w_hs && ((state_q == ST_ACTIVE) || !aw_empty);
        w_orphan = w_hs && (state_q == ST_IDLE) && aw_empty;
        len_mis  = beat_en && (w_last_i ? (beat != cur.len) : (beat == cur.len));
        lo_vld   = 1'b0;
        lo_byte  = 8'd0;
        for (int i = STRB_W - 1; i >= 0; i--) begin
            if (w_strb_i[i]) begin
                lo_vld  = 1'b1;
                lo_byte = w_data_i[8*i +: 8];
            end
        end
        char_push = beat_en && (cur.kind == KIND_STDOUT) && lo_vld && (lo_byte != 8'd0);
        err_hit   = beat_en && (cur.kind == KIND_STDERR);
        eoc_hit   = beat_en && (cur.kind == KIND_EOC) && !eoc_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_q  <= '0;
            beat_q <= '0;
        end else begin
            if (aw_pop) cur_q <= aw_head;
            beat_q <= beat_en ? beat + 8'd1 : beat;
        end
    end

`ifdef MAGIA_MON_TIMESTAMP_EN
    logic [63:0] cycle_q;
    logic [63:0] err_ts_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_q  <= '0;
            err_ts_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (err_hit) err_ts_q <= cycle_q;
        end
    end

    assign char_new = '{data: lo_byte, ch: cur.ch, ts: cycle_q};
    assign ts_o     = err_valid_q ? err_ts_q : char_head.ts;
`else
    assign char_new = '{data: lo_byte, ch: cur.ch};
`endif

    assign char_pop = char_valid_o & char_ready_i;

    fifo_v3 #(
        .DEPTH (CHAR_DEPTH),
        .dtype (char_entry_t)
    ) i_char_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (char_full),
        .empty_o (char_empty),
        .data_i  (char_new),
        .push_i  (char_push),
        .data_o  (char_head),
        .pop_i   (char_pop)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_valid_q <= 1'b0;
            err_ch_q    <= '0;
            err_code_q  <= '0;
            eoc_q       <= 1'b0;
            exit_code_q <= '0;
            st_w_early  <= 1'b0;
            st_aw_ovf   <= 1'b0;
            st_char_ovf <= 1'b0;
            st_len_err  <= 1'b0;
        end else begin
            err_valid_q <= err_hit;
            if (err_hit) begin
                err_ch_q   <= cur.ch[CH_W-1:0];
                err_code_q <= w_data_i[31:0];
            end
            if (eoc_hit) begin
                eoc_q       <= 1'b1;
                exit_code_q <= w_data_i[31:0];
            end
            if (w_orphan)                           st_w_early  <= 1'b1;
            if (aw_hs && aw_full && !aw_pop)        st_aw_ovf   <= 1'b1;
            if (char_push && char_full && !char_pop) st_char_ovf <= 1'b1;
            if (len_mis)                            st_len_err  <= 1'b1;
        end
    end

    assign char_valid_o = !char_empty;
    assign char_data_o  = char_head.data;
    assign char_ch_o    = char_head.ch[CH_W-1:0];
    assign err_valid_o  = err_valid_q;
    assign err_ch_o     = err_ch_q;
    assign err_code_o   = err_code_q;
    assign eoc_o        = eoc_q;
    assign exit_code_o  = exit_code_q;
    assign status_o     = {st_w_early, st_aw_ovf, st_char_ovf, st_len_err};
    assign unused_ch    = ^{char_head.ch, cur.ch};

endmodule

// File: tb/tb_magia_axi_print_monitor.sv
// Directed self-checking bench for magia_axi_print_monitor (default parameters).
module tb_magia_axi_print_monitor;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        aw_valid = 1'b0;
    logic        aw_ready = 1'b1;
    logic [31:0] aw_addr = '0;
    logic [7:0]  aw_len = '0;
    logic        w_valid = 1'b0;
    logic        w_ready = 1'b1;
    logic [31:0] w_data = '0;
    logic [3:0]  w_strb = '0;
    logic        w_last = 1'b0;
    logic        char_valid;
    logic        char_ready = 1'b0;
    logic [7:0]  char_data;
    logic [1:0]  char_ch;
    logic        err_valid;
    logic [1:0]  err_ch;
    logic [31:0] err_code;
    logic        eoc;
    logic [31:0] exit_code;
    logic [3:0]  status;
`ifdef MAGIA_MON_TIMESTAMP_EN
    logic [63:0] ts;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    magia_axi_print_monitor dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .aw_valid_i   (aw_valid),
        .aw_ready_i   (aw_ready),
        .aw_addr_i    (aw_addr),
        .aw_len_i     (aw_len),
        .w_valid_i    (w_valid),
        .w_ready_i    (w_ready),
        .w_data_i     (w_data),
        .w_strb_i     (w_strb),
        .w_last_i     (w_last),
        .char_valid_o (char_valid),
        .char_ready_i (char_ready),
        .char_data_o  (char_data),
        .char_ch_o    (char_ch),
        .err_valid_o  (err_valid),
        .err_ch_o     (err_ch),
        .err_code_o   (err_code),
        .eoc_o        (eoc),
        .exit_code_o  (exit_code),
        .status_o     (status)
`ifdef MAGIA_MON_TIMESTAMP_EN
        ,
        .ts_o         (ts)
`endif
    );

    task automatic do_reset();
        rst_ni = 1'b0;
        aw_valid = 1'b0;
        w_valid = 1'b0;
        char_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [7:0] len);
        aw_addr = addr;
        aw_len = len;
        aw_valid = 1'b1;
        @(posedge clk);
        #1 aw_valid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        w_data = data;
        w_strb = strb;
        w_last = last;
        w_valid = 1'b1;
        @(posedge clk);
        #1 w_valid = 1'b0;
        w_last = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({char_valid, char_data, char_ch, err_valid, err_ch, err_code, eoc, exit_code, status} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b data=%h status=%b eoc=%b want all zero",
                     char_valid, char_data, status, eoc);
        end
    endtask

    task automatic test_stdout();
        send_aw(32'h5FFF_000C, 8'd0);
        checks++;
        if (char_valid !== 1'b0) begin
            errors++;
            $display("FAIL stdout_pre_valid got %b want 0", char_valid);
        end
        send_w(32'h0000_0048, 4'b0001, 1'b1);
        checks++;
        if ({char_valid, char_data, char_ch} !== {1'b1, 8'h48, 2'd1}) begin
            errors++;
            $display("FAIL stdout_char got v=%b d=%h ch=%0d want v=1 d=48 ch=1", char_valid, char_data, char_ch);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({char_valid, char_data} !== {1'b1, 8'h48}) begin
            errors++;
            $display("FAIL stdout_hold got v=%b d=%h want v=1 d=48", char_valid, char_data);
        end
        char_ready = 1'b1;
        @(posedge clk);
        #1 char_ready = 1'b0;
        checks++;
        if (char_valid !== 1'b0) begin
            errors++;
            $display("FAIL stdout_popped got %b want 0", char_valid);
        end
    endtask

    task automatic test_ordering();
        send_aw(32'h4000_0000, 8'd1);
        send_aw(32'h5FFF_0004, 8'd0);
        send_w(32'h0000_0041, 4'b0001, 1'b0);
        checks++;
        if (char_valid !== 1'b0) begin
            errors++;
            $display("FAIL order_none_beat got %b want 0", char_valid);
        end
        send_w(32'h0000_0042, 4'b0001, 1'b1);
        send_w(32'h0000_0043, 4'b0001, 1'b1);
        checks++;
        if ({char_valid, char_data, char_ch, status} !== {1'b1, 8'h43, 2'd0, 4'b0000}) begin
            errors++;
            $display("FAIL order_char got v=%b d=%h ch=%0d st=%b want v=1 d=43 ch=0 st=0000",
                     char_valid, char_data, char_ch, status);
        end
        char_ready = 1'b1;
        @(posedge clk);
        #1 char_ready = 1'b0;
        checks++;
        if (char_valid !== 1'b0) begin
            errors++;
            $display("FAIL order_single got %b want 0", char_valid);
        end
    endtask

    task automatic test_stderr_eoc();
        send_aw(32'h5FFF_0000, 8'd0);
        send_w(32'h0000_0003, 4'b1111, 1'b1);
        checks++;
        if ({err_valid, err_code, err_ch} !== {1'b1, 32'd3, 2'd0}) begin
            errors++;
            $display("FAIL stderr_pulse got v=%b code=%h ch=%0d want v=1 code=3 ch=0", err_valid, err_code, err_ch);
        end
        @(posedge clk);
        #1;
        checks++;
        if (err_valid !== 1'b0) begin
            errors++;
            $display("FAIL stderr_one_cycle got %b want 0", err_valid);
        end
        send_aw(32'h5C03_0000, 8'd0);
        send_w(32'h0000_0000, 4'b1111, 1'b1);
        checks++;
        if ({eoc, exit_code} !== {1'b1, 32'd0}) begin
            errors++;
            $display("FAIL eoc_first got eoc=%b exit=%h want eoc=1 exit=0", eoc, exit_code);
        end
        send_aw(32'h5C03_0000, 8'd0);
        send_w(32'h0000_0007, 4'b1111, 1'b1);
        checks++;
        if ({eoc, exit_code, char_valid, status} !== {1'b1, 32'd0, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL eoc_second got eoc=%b exit=%h cv=%b st=%b want eoc=1 exit=0 cv=0 st=0000",
                     eoc, exit_code, char_valid, status);
        end
    endtask

    task automatic test_protocol();
        do_reset();
        send_w(32'h0000_0055, 4'b0001, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if ({status, char_valid, err_valid} !== {4'b1000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL w_early got st=%b cv=%b ev=%b want st=1000 cv=0 ev=0", status, char_valid, err_valid);
        end
        send_aw(32'h5FFF_0004, 8'd2);
        send_w(32'h0000_0061, 4'b0001, 1'b0);
        send_w(32'h0000_0062, 4'b0001, 1'b1);
        checks++;
        if (status !== 4'b1001) begin
            errors++;
            $display("FAIL len_err got %b want 1001", status);
        end
    endtask

    task automatic test_char_overflow();
        int n;
        logic [7:0] first;
        logic [7:0] last;
        do_reset();
        send_aw(32'h5FFF_0004, 8'd19);
        for (int i = 0; i < 20; i++) send_w(32'h61 + i, 4'b0001, i == 19);
        checks++;
        if (status !== 4'b0010) begin
            errors++;
            $display("FAIL char_ovf_status got %b want 0010", status);
        end
        n = 0;
        first = 8'h00;
        last = 8'h00;
        char_ready = 1'b1;
        while (char_valid && n < 40) begin
            if (n == 0) first = char_data;
            last = char_data;
            @(posedge clk);
            #1;
            n++;
        end
        char_ready = 1'b0;
        checks++;
        if ({n, first, last} !== {32'd16, 8'h61, 8'h70}) begin
            errors++;
            $display("FAIL char_ovf_drain got n=%0d first=%h last=%h want n=16 first=61 last=70", n, first, last);
        end
    endtask

    task automatic test_aw_overflow();
        do_reset();
        // First AW is absorbed into the burst register, so eight more just fill the FIFO.
        for (int i = 0; i < 9; i++) send_aw(32'h5FFF_0004, 8'd0);
        checks++;
        if (status !== 4'b0000) begin
            errors++;
            $display("FAIL aw_fill got %b want 0000", status);
        end
        send_aw(32'h5FFF_0004, 8'd0);
        checks++;
        if (status !== 4'b0100) begin
            errors++;
            $display("FAIL aw_ovf got %b want 0100", status);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        send_aw(32'h5C03_0000, 8'd0);
        send_w(32'h0000_0009, 4'b1111, 1'b1);
        send_aw(32'h5FFF_0004, 8'd3);
        send_w(32'h0000_0031, 4'b0001, 1'b0);
        checks++;
        if ({char_valid, eoc, exit_code} !== {1'b1, 1'b1, 32'd9}) begin
            errors++;
            $display("FAIL pre_reset got cv=%b eoc=%b exit=%h want cv=1 eoc=1 exit=9", char_valid, eoc, exit_code);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({char_valid, char_data, eoc, exit_code, status, err_valid} !== '0) begin
            errors++;
            $display("FAIL async_reset got cv=%b d=%h eoc=%b exit=%h st=%b want all zero",
                     char_valid, char_data, eoc, exit_code, status);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        send_w(32'h0000_0032, 4'b0001, 1'b0);
        checks++;
        if ({status, char_valid} !== {4'b1000, 1'b0}) begin
            errors++;
            $display("FAIL orphan_after_reset got st=%b cv=%b want st=1000 cv=0", status, char_valid);
        end
        send_aw(32'h5FFF_000C, 8'd0);
        send_w(32'h0000_5A00, 4'b0010, 1'b1);
        checks++;
        if ({char_valid, char_data, char_ch} !== {1'b1, 8'h5A, 2'd1}) begin
            errors++;
            $display("FAIL clean_print got v=%b d=%h ch=%0d want v=1 d=5a ch=1", char_valid, char_data, char_ch);
        end
    endtask

    initial begin
        test_reset();
        test_stdout();
        test_ordering();
        test_stderr_eoc();
        test_protocol();
        test_char_overflow();
        test_aw_overflow();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
